aes_ctrl_input_stage: RTL and testbench

Input stage of the AES controller. Takes 32-bit write beats from the slave bus and packs them into 128-bit AES blocks. Each block is stored with its packet-end flag in an internal FIFO. The processing FSM reads these entries through a valid/ready interface, and the block applies backpressure to the bus through a busy flag.

---
 rtl/aes_ctrl_input_stage_pkg.sv | 16 +
 rtl/aes_ctrl_input_stage_sync_fifo.sv | 55 +++++
 rtl/aes_ctrl_input_stage.sv | 103 ++++++++++
 tb/tb_aes_ctrl_input_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_input_stage_pkg.sv
// Shared AES sizes and the ceil-log2 helper used to size counters.
package aes_ctrl_input_stage_pkg;

   localparam int unsigned BLK_S    = 128;
   localparam int unsigned WORD_S   = 32;
   localparam int unsigned CMD_BITS = 32;

   // Bits needed to hold values 0..n-1; never less than one bit.
   function automatic int unsigned clogb2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r = r + 1;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/aes_ctrl_input_stage_sync_fifo.sv
// Generic first-word-fall-through FIFO; the head entry is visible on rdata
// whenever empty is low. Storage itself is not reset.
module sync_fifo #(
   parameter int unsigned DATA_W = 129,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              do_wr;
   logic              do_rd;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap modulo DEPTH so non power-of-two depths also work.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr)
            wr_ptr <= (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + ADDR_W'(1);
         if (do_rd)
            rd_ptr <= (rd_ptr == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr + ADDR_W'(1);
         if (do_wr && !do_rd)
            count <= count + CNT_W'(1);
         else if (do_rd && !do_wr)
            count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/aes_ctrl_input_stage.sv
// AES controller input stage: packs bus words into 128-bit blocks tagged with
// the packet-end flag and queues them in a FWFT FIFO for the processing FSM.
module aes_ctrl_input_stage
   import aes_ctrl_input_stage_pkg::*;
#(
   parameter int unsigned BUS_DATA_WIDTH  = 32,
   parameter int unsigned FIFO_DATA_WIDTH = 129,
   parameter int unsigned FIFO_SIZE       = 256,
   parameter int unsigned FIFO_ADDR_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       bus_data_wren,
   input  logic                       bus_tlast,
   input  logic [BUS_DATA_WIDTH-1:0]  bus_data,
   output logic                       in_fifo_read_tvalid,
   input  logic                       in_fifo_read_tready,
   output logic [FIFO_DATA_WIDTH-1:0] in_fifo_rdata,
   output logic                       in_fifo_empty,
   output logic                       controller_in_busy
);

   localparam int unsigned N     = BLK_S / BUS_DATA_WIDTH;
   localparam int unsigned CNT_W = clogb2(N);
   localparam int unsigned OCC_W = FIFO_ADDR_WIDTH + 1;

   logic                       pkt_start;
   logic [CNT_W-1:0]           word_cnt;
   logic [BLK_S-1:0]           blk;

   logic                       start_next;
   logic [CNT_W-1:0]           cnt_next;
   logic [BLK_S-1:0]           blk_next;
   logic [BLK_S-1:0]           blk_fill;
   logic                       accept;
   logic                       push;
   logic [FIFO_DATA_WIDTH-1:0] push_data;
   logic                       fifo_full;
   logic [OCC_W-1:0]           fifo_count;

   assign controller_in_busy  = (fifo_count >= OCC_W'(FIFO_SIZE - 1));
   assign accept              = bus_data_wren && !controller_in_busy;
   assign in_fifo_read_tvalid = !in_fifo_empty;

   // Command word goes out alone; data words fill from the MSB end.
   always_comb begin
      push       = 1'b0;
      push_data  = '0;
      start_next = pkt_start;
      cnt_next   = word_cnt;
      blk_next   = blk;
      blk_fill   = blk;
      for (int k = 0; k < N; k++) begin
         if (word_cnt == CNT_W'(k))
            blk_fill[BLK_S-1-k*BUS_DATA_WIDTH -: BUS_DATA_WIDTH] = bus_data;
      end
      if (accept) begin
         if (pkt_start) begin
            push       = 1'b1;
            push_data  = {bus_tlast, BLK_S'(bus_data)};
            start_next = bus_tlast;
         end else if (word_cnt == CNT_W'(N - 1) || bus_tlast) begin
            push       = 1'b1;
            push_data  = {bus_tlast, blk_fill};
            start_next = bus_tlast;
            cnt_next   = '0;
            blk_next   = '0;
         end else begin
            cnt_next = word_cnt + CNT_W'(1);
            blk_next = blk_fill;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_start <= 1'b1;
         word_cnt  <= '0;
         blk       <= '0;
      end else begin
         pkt_start <= start_next;
         word_cnt  <= cnt_next;
         blk       <= blk_next;
      end
   end

   sync_fifo #(
      .DATA_W (FIFO_DATA_WIDTH),
      .DEPTH  (FIFO_SIZE),
      .ADDR_W (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr_en (push && !fifo_full),
      .wdata (push_data),
      .rd_en (in_fifo_read_tvalid && in_fifo_read_tready),
      .rdata (in_fifo_rdata),
      .full  (fifo_full),
      .empty (in_fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_aes_ctrl_input_stage.sv
// Bench for aes_ctrl_input_stage: queue-based packet model checked every
// cycle, plus literal expectations for directed packets.
module tb_aes_ctrl_input_stage;

   localparam int unsigned W     = 32;
   localparam int unsigned DW    = 129;
   localparam int unsigned FSIZE = 4;
   localparam int unsigned AW    = 2;

   logic          clk;
   logic          reset;
   logic          bus_data_wren;
   logic          bus_tlast;
   logic [W-1:0]  bus_data;
   logic          in_fifo_read_tvalid;
   logic          in_fifo_read_tready;
   logic [DW-1:0] in_fifo_rdata;
   logic          in_fifo_empty;
   logic          controller_in_busy;

   int checks   = 0;
   int failures = 0;
   bit rand_ready = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] popped[$];
   logic [W-1:0]  words[$];
   bit            in_start;

   aes_ctrl_input_stage #(
      .BUS_DATA_WIDTH  (W),
      .FIFO_DATA_WIDTH (DW),
      .FIFO_SIZE       (FSIZE),
      .FIFO_ADDR_WIDTH (AW)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .bus_data_wren       (bus_data_wren),
      .bus_tlast           (bus_tlast),
      .bus_data            (bus_data),
      .in_fifo_read_tvalid (in_fifo_read_tvalid),
      .in_fifo_read_tready (in_fifo_read_tready),
      .in_fifo_rdata       (in_fifo_rdata),
      .in_fifo_empty       (in_fifo_empty),
      .controller_in_busy  (controller_in_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Packet-level model: queue of entries, busy when FSIZE-1 are held.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q.delete();
         words.delete();
         in_start = 1'b1;
      end else begin
         bit busy_m;
         logic [127:0] b;
         busy_m = (q.size() >= FSIZE - 1);
         if (q.size() > 0 && in_fifo_read_tready) begin
            popped.push_back(in_fifo_rdata);
            void'(q.pop_front());
         end
         if (bus_data_wren && !busy_m) begin
            if (in_start) begin
               q.push_back({bus_tlast, 96'h0, bus_data});
               in_start = bus_tlast;
            end else begin
               words.push_back(bus_data);
               if (words.size() == 128 / W || bus_tlast) begin
                  b = '0;
                  foreach (words[i]) b[127 - 32*i -: 32] = words[i];
                  q.push_back({bus_tlast, b});
                  words.delete();
                  in_start = bus_tlast;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("tvalid", 129'(in_fifo_read_tvalid), 129'(q.size() != 0));
         chk("empty", 129'(in_fifo_empty), 129'(q.size() == 0));
         chk("busy", 129'(controller_in_busy), 129'(q.size() >= FSIZE - 1));
         if (q.size() != 0) chk("rdata", in_fifo_rdata, q[0]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) in_fifo_read_tready = 1'($urandom_range(0, 1));
   endtask

   task automatic raw_beat(input logic [W-1:0] d, input bit last);
      bus_data = d; bus_tlast = last; bus_data_wren = 1'b1;
      step();
      bus_data_wren = 1'b0; bus_tlast = 1'b0;
   endtask

   task automatic send_beat(input logic [W-1:0] d, input bit last);
      int n = 0;
      while (controller_in_busy && n < 200) begin step(); n++; end
      if (n >= 200) chk("busy_timeout", 129'(1), 129'(0));
      raw_beat(d, last);
   endtask

   task automatic drain();
      int n = 0;
      in_fifo_read_tready = 1'b1;
      while (!in_fifo_empty && n < 100) begin step(); n++; end
      if (n >= 100) chk("drain_timeout", 129'(1), 129'(0));
      in_fifo_read_tready = 1'b0;
   endtask

   initial begin
      int base;
      reset = 1'b1; bus_data_wren = 1'b0; bus_tlast = 1'b0; bus_data = '0;
      in_fifo_read_tready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_tvalid", 129'(in_fifo_read_tvalid), 129'(0));
      chk("rst_empty", 129'(in_fifo_empty), 129'(1));
      chk("rst_busy", 129'(controller_in_busy), 129'(0));
      step();

      // Full packet with the FIFO held: fills to busy, then an extra beat drops.
      raw_beat(32'h11, 0);
      raw_beat(32'hA0, 0); raw_beat(32'hA1, 0); raw_beat(32'hA2, 0); raw_beat(32'hA3, 0);
      raw_beat(32'hB0, 0); raw_beat(32'hB1, 0); raw_beat(32'hB2, 0); raw_beat(32'hB3, 1);
      chk("busy_at_3", 129'(controller_in_busy), 129'(1));
      raw_beat(32'h99, 0);
      chk("busy_after_drop", 129'(controller_in_busy), 129'(1));
      in_fifo_read_tready = 1'b1;
      step();
      in_fifo_read_tready = 1'b0;
      chk("busy_clears", 129'(controller_in_busy), 129'(0));
      drain();
      chk("full_pkt_count", 129'(popped.size()), 129'(3));
      chk("entry_cmd", popped[0], {1'b0, 128'h11});
      chk("entry_a", popped[1], {1'b0, 32'hA0, 32'hA1, 32'hA2, 32'hA3});
      chk("entry_b", popped[2], {1'b1, 32'hB0, 32'hB1, 32'hB2, 32'hB3});

      // Short block, then a lone command word.
      base = popped.size();
      raw_beat(32'h22, 0); raw_beat(32'hC0, 0); raw_beat(32'hC1, 1);
      drain();
      chk("short_count", 129'(popped.size() - base), 129'(2));
      chk("short_cmd", popped[base], {1'b0, 128'h22});
      chk("short_blk", popped[base+1], {1'b1, 32'hC0, 32'hC1, 64'h0});
      raw_beat(32'h33, 0);

      // Push and pop in the same cycle at occupancy one.
      base = popped.size();
      bus_data = 32'hD0; bus_tlast = 1'b1; bus_data_wren = 1'b1;
      in_fifo_read_tready = 1'b1;
      step();
      bus_data_wren = 1'b0; bus_tlast = 1'b0; in_fifo_read_tready = 1'b0;
      chk("cc_not_empty", 129'(in_fifo_empty), 129'(0));
      chk("cc_head", in_fifo_rdata, {1'b1, 32'hD0, 96'h0});
      chk("cc_popped", popped[base], {1'b0, 128'h33});
      step();
      chk("cc_still_one", 129'(in_fifo_read_tvalid), 129'(1));
      drain();

      // Asynchronous reset in the middle of a packet.
      raw_beat(32'h55, 0); raw_beat(32'h66, 0);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("arst_tvalid", 129'(in_fifo_read_tvalid), 129'(0));
      chk("arst_empty", 129'(in_fifo_empty), 129'(1));
      chk("arst_busy", 129'(controller_in_busy), 129'(0));
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      step(); step();
      chk("arst_no_entry", 129'(in_fifo_empty), 129'(1));
      base = popped.size();
      raw_beat(32'h77, 0); raw_beat(32'h88, 1);
      drain();
      chk("arst_cmd", popped[base], {1'b0, 128'h77});
      chk("arst_blk", popped[base+1], {1'b1, 32'h88, 96'h0});

      // Wrap-around stream with random backpressure.
      base = popped.size();
      rand_ready = 1'b1;
      for (int p = 0; p < 6; p++) begin
         send_beat(32'h1000 + 32'(p), 0);
         for (int i = 0; i < 4; i++) send_beat(32'h2000 + 32'(p*16 + i), i == 3);
      end
      rand_ready = 1'b0;
      drain();
      chk("wrap_count", 129'(popped.size() - base), 129'(12));
      chk("wrap_last", popped[popped.size()-1],
          {1'b1, 32'h2050, 32'h2051, 32'h2052, 32'h2053});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
